// File: rtl/m92_pkg.sv
// Shared types for the M92 object renderer front end: descriptor layout,
// fetch FSM states and the row entry carried through the output FIFO.
package m92_pkg;

    localparam int OBJ_TILE_PX = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_REQ,
        S_WAIT,
        S_DRAIN
    } fetch_state_e;

    typedef struct packed {
        logic [5:0]  rsv_hi;
        logic [9:0]  org_x;
        logic [5:0]  rsv_mid;
        logic        flipy;
        logic        flipx;
        logic        prio;
        logic [6:0]  color;
        logic [15:0] code;
        logic [2:0]  rsv_lo;
        logic [1:0]  width;
        logic [1:0]  height;
        logic [8:0]  org_y;
    } obj_desc_t;

    typedef struct packed {
        logic [63:0] data;
        logic [9:0]  x;
        logic [6:0]  color;
        logic        prio;
        logic        flip;
    } obj_row_t;

    localparam int OBJ_ROW_W = $bits(obj_row_t);

endpackage

// File: rtl/obj_fetch_fifo.sv
// Show-ahead FIFO holding fetched sprite rows; head is visible on rdata while
// not empty. Push and pop in the same cycle are both honoured, even when full.
module obj_fetch_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 83,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk_ram,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk_ram) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_ram) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/obj_row_fetcher.sv
// Sprite row fetch engine: culls descriptors against the current line and
// issues one SDRAM read per 16px span, queueing tagged bitplane words.
module obj_row_fetcher
    import m92_pkg::*;
#(
    parameter logic [24:0] BASE_ADDR   = 25'h0,
    parameter int          FIFO_DEPTH  = 4,
    parameter int          CODE_STRIDE = 8
) (
    input  logic        clk_ram,
    input  logic        reset,
    input  logic        line_start,
    input  logic [8:0]  v_line,
    input  logic        desc_valid,
    output logic        desc_ready,
    input  logic [63:0] desc_in,
    output logic [24:0] sdr_addr,
    output logic        sdr_req,
    input  logic        sdr_rdy,
    input  logic [63:0] sdr_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic [9:0]  out_x,
    output logic [6:0]  out_color,
    output logic        out_prio,
    output logic        out_flip,
    output logic        busy
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    function automatic logic [8:0] obj_height_px(input logic [1:0] h);
        return 9'(OBJ_TILE_PX) << h;
    endfunction

    function automatic logic [2:0] last_span(input logic [1:0] w);
        return 3'((4'd1 << w) - 4'd1);
    endfunction

    // flipx mirrors the tile column only; spans are always fetched left to right
    function automatic logic [24:0] fetch_addr(input obj_desc_t d, input logic [8:0] row_y,
                                               input logic [2:0] span);
        logic [2:0]  col;
        logic [15:0] code;
        col  = d.flipx ? last_span(d.width) - span : span;
        code = d.code + 16'(row_y[8:4]) + 16'(col) * 16'(CODE_STRIDE);
        return BASE_ADDR + {2'b00, code, row_y[3:0], 3'b000};
    endfunction

    fetch_state_e   state_q, state_d;
    obj_desc_t      desc_q;
    logic [8:0]     vline_q;
    logic [8:0]     row_y_q, row_y_d;
    logic [2:0]     span_q, span_d;
    logic [24:0]    sdr_addr_q, addr_d;
    logic [8:0]     hpx, rel_y, row_calc;
    logic           accept;
    logic           push;
    logic           pop;
    obj_row_t       row_w;
    obj_row_t       head;
    logic [OBJ_ROW_W-1:0] fifo_rdata;
    logic [CW-1:0]  fifo_count;
    logic           fifo_full;
    logic           fifo_empty;
    logic           desc_unused;

    assign desc_unused = ^{desc_q.rsv_hi, desc_q.rsv_mid, desc_q.rsv_lo};

    assign desc_ready = (state_q == S_IDLE) && !line_start && !reset;
    assign accept     = desc_valid && desc_ready;
    assign sdr_addr   = sdr_addr_q;
    assign busy       = (state_q != S_IDLE) || (fifo_count != '0);

    always_ff @(posedge clk_ram) begin
        if (reset) begin
            state_q    <= S_IDLE;
            span_q     <= '0;
            sdr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            span_q     <= span_d;
            sdr_addr_q <= addr_d;
        end
    end

    always_ff @(posedge clk_ram) begin
        if (accept) begin
            desc_q  <= obj_desc_t'(desc_in);
            vline_q <= v_line;
        end
        row_y_q <= row_y_d;
    end

    always_comb begin
        state_d  = state_q;
        span_d   = span_q;
        addr_d   = sdr_addr_q;
        row_y_d  = row_y_q;
        push     = 1'b0;
        sdr_req  = 1'b0;
        hpx      = obj_height_px(desc_q.height);
        rel_y    = vline_q + desc_q.org_y + hpx;
        row_calc = desc_q.flipy ? hpx - 9'd1 - rel_y : rel_y;
        if (line_start) begin
            // an outstanding read still has to be swallowed unless it lands right now
            span_d  = '0;
            state_d = ((state_q == S_WAIT || state_q == S_DRAIN) && !sdr_rdy) ? S_DRAIN : S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        state_d = S_CALC;
                        span_d  = '0;
                    end
                end
                S_CALC: begin
                    if (rel_y < hpx) begin
                        row_y_d = row_calc;
                        addr_d  = fetch_addr(desc_q, row_calc, 3'd0);
                        state_d = S_REQ;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_REQ: begin
                    if (!fifo_full) begin
                        sdr_req = 1'b1;
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (sdr_rdy) begin
                        push = 1'b1;
                        if (span_q == last_span(desc_q.width)) begin
                            span_d  = '0;
                            state_d = S_IDLE;
                        end else begin
                            span_d  = span_q + 3'd1;
                            addr_d  = fetch_addr(desc_q, row_y_q, span_q + 3'd1);
                            state_d = S_REQ;
                        end
                    end
                end
                S_DRAIN: begin
                    if (sdr_rdy) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        row_w.data  = sdr_data;
        row_w.x     = desc_q.org_x + {3'b000, span_q, 4'b0000};
        row_w.color = desc_q.color;
        row_w.prio  = desc_q.prio;
        row_w.flip  = desc_q.flipx;
    end

    assign pop       = out_valid && out_ready;
    assign out_valid = !fifo_empty;
    assign head      = obj_row_t'(fifo_rdata);
    assign out_data  = head.data;
    assign out_x     = head.x;
    assign out_color = head.color;
    assign out_prio  = head.prio;
    assign out_flip  = head.flip;

    obj_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (OBJ_ROW_W)
    ) u_fifo (
        .clk_ram (clk_ram),
        .reset   (reset),
        .flush   (line_start),
        .push    (push),
        .wdata   (row_w),
        .pop     (pop),
        .rdata   (fifo_rdata),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_obj_row_fetcher.sv
// Directed bench for obj_row_fetcher: a per-descriptor expectation model feeds
// queues that a compare process checks against every request and every pop.
module tb_obj_row_fetcher;

    localparam logic [24:0] BASE = 25'h40000;

    logic        clk_ram = 1'b0;
    logic        reset;
    logic        line_start;
    logic [8:0]  v_line;
    logic        desc_valid;
    logic        desc_ready;
    logic [63:0] desc_in;
    logic [24:0] sdr_addr;
    logic        sdr_req;
    logic        sdr_rdy;
    logic [63:0] sdr_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [9:0]  out_x;
    logic [6:0]  out_color;
    logic        out_prio;
    logic        out_flip;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int req_cnt = 0;
    int out_cnt = 0;
    int rdy_delay = 1;
    logic [9:0]  last_x;
    logic [24:0] exp_addr [$];
    logic [82:0] exp_out [$];
    logic [24:0] req_log [$];
    logic [9:0]  x_log [$];

    obj_row_fetcher #(
        .BASE_ADDR   (BASE),
        .FIFO_DEPTH  (2),
        .CODE_STRIDE (8)
    ) dut (
        .clk_ram    (clk_ram),
        .reset      (reset),
        .line_start (line_start),
        .v_line     (v_line),
        .desc_valid (desc_valid),
        .desc_ready (desc_ready),
        .desc_in    (desc_in),
        .sdr_addr   (sdr_addr),
        .sdr_req    (sdr_req),
        .sdr_rdy    (sdr_rdy),
        .sdr_data   (sdr_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_x      (out_x),
        .out_color  (out_color),
        .out_prio   (out_prio),
        .out_flip   (out_flip),
        .busy       (busy)
    );

    initial forever #5 clk_ram = ~clk_ram;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] memd(input logic [24:0] a);
        return {7'h55, a, 7'h2A, ~a};
    endfunction

    function automatic logic [63:0] mk_desc(input int oy, input int h, input int w, input int code,
                                            input int color, input int prio, input int fx,
                                            input int fy, input int ox);
        logic [63:0] d;
        d        = '0;
        d[8:0]   = 9'(oy);
        d[10:9]  = 2'(h);
        d[12:11] = 2'(w);
        d[31:16] = 16'(code);
        d[38:32] = 7'(color);
        d[39]    = 1'(prio);
        d[40]    = 1'(fx);
        d[41]    = 1'(fy);
        d[57:48] = 10'(ox);
        return d;
    endfunction

    // Expected request addresses and FIFO entries for one descriptor on line v.
    task automatic model_desc(input logic [63:0] d, input int v);
        int oy, h, w, code, color, prio, fx, fy, ox;
        int hpx, rel, row, n, c, cd, a, x;
        oy = int'(d[8:0]);   h = int'(d[10:9]);   w = int'(d[12:11]);
        code = int'(d[31:16]); color = int'(d[38:32]); prio = int'(d[39]);
        fx = int'(d[40]);    fy = int'(d[41]);    ox = int'(d[57:48]);
        hpx = 16 << h;
        rel = (v + oy + hpx) % 512;
        if (rel >= hpx) return;
        row = fy ? hpx - 1 - rel : rel;
        n = 1 << w;
        for (int s = 0; s < n; s++) begin
            c  = fx ? n - 1 - s : s;
            cd = (code + row / 16 + c * 8) % 65536;
            a  = (int'(BASE) + cd * 128 + (row % 16) * 8) % (1 << 25);
            x  = (ox + 16 * s) % 1024;
            exp_addr.push_back(25'(a));
            exp_out.push_back({memd(25'(a)), 10'(x), 7'(color), 1'(prio), 1'(fx)});
        end
    endtask

    // SDRAM model: answers each request rdy_delay cycles later with address-derived data.
    initial begin
        logic [24:0] a;
        sdr_rdy  = 1'b0;
        sdr_data = '0;
        forever begin
            @(negedge clk_ram);
            if (sdr_req && !reset) begin
                a = sdr_addr;
                repeat (rdy_delay) @(posedge clk_ram);
                #1;
                sdr_rdy  = 1'b1;
                sdr_data = memd(a);
                @(posedge clk_ram);
                #1;
                sdr_rdy = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_ram);
            if (!reset) begin
                if (sdr_req) begin
                    req_cnt++;
                    req_log.push_back(sdr_addr);
                    if (exp_addr.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL req_unexpected: got request at %0h, expected none", sdr_addr);
                    end else chk("req_addr", sdr_addr, exp_addr.pop_front());
                end
                if (out_valid && out_ready) begin
                    out_cnt++;
                    last_x = out_x;
                    x_log.push_back(out_x);
                    if (exp_out.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL out_unexpected: got x=%0h data=%0h, expected no output", out_x, out_data);
                    end else chk("out_entry", {out_data, out_x, out_color, out_prio, out_flip}, exp_out.pop_front());
                end
            end
        end
    end

    task automatic send_desc(input logic [63:0] d, input int v);
        bit acc;
        acc = 1'b0;
        @(posedge clk_ram); #1;
        desc_in = d; v_line = 9'(v); desc_valid = 1'b1;
        for (int i = 0; i < 60 && !acc; i++) begin
            @(negedge clk_ram);
            if (desc_ready) acc = 1'b1;
        end
        if (!acc) begin
            checks++; errors++;
            $display("FAIL desc_accept: got desc_ready=0 for 60 cycles, expected 1");
        end
        @(posedge clk_ram); #1;
        desc_valid = 1'b0;
        if (acc) model_desc(d, v);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 300 && busy; i++) @(negedge clk_ram);
        @(negedge clk_ram);
        chk(name, busy, 0);
    endtask

    initial begin
        int base_req, base_out;
        logic [24:0] t2_addr [4];
        logic [9:0]  t2_x [4];
        t2_addr = '{25'h41C00, 25'h41800, 25'h41400, 25'h41000};
        t2_x    = '{10'h3F0, 10'h000, 10'h010, 10'h020};
        reset = 1'b1; line_start = 1'b0; v_line = '0; desc_valid = 1'b0;
        desc_in = '0; out_ready = 1'b1;

        repeat (3) @(posedge clk_ram);
        @(negedge clk_ram);
        chk("rst_desc_ready", desc_ready, 0);
        chk("rst_sdr_req", sdr_req, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sdr_addr", sdr_addr, 0);
        @(posedge clk_ram); #1;
        reset = 1'b0;
        @(negedge clk_ram);
        chk("idle_desc_ready", desc_ready, 1);

        // single span, org_y wraps so that line 0 is row 0
        base_out = out_cnt;
        send_desc(mk_desc(496, 0, 0, 'h100, 'h11, 1, 0, 0, 'h123), 0);
        @(negedge clk_ram);
        chk("lat_calc_noreq", sdr_req, 0);
        @(negedge clk_ram);
        chk("lat_req", sdr_req, 1);
        chk("t1_addr", sdr_addr, 25'h48000);
        wait_idle("t1_idle");
        chk("t1_out_count", out_cnt - base_out, 1);
        chk("t1_out_x", last_x, 10'h123);

        // four spans with flipx: tile columns reversed, x still steps left to right
        req_log.delete(); x_log.delete();
        send_desc(mk_desc(496, 0, 2, 'h20, 'h05, 0, 1, 0, 'h3F0), 0);
        wait_idle("t2_idle");
        chk("t2_req_count", req_log.size(), 4);
        chk("t2_out_count", x_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < req_log.size()) chk($sformatf("t2_addr%0d", i), req_log[i], t2_addr[i]);
            if (i < x_log.size())   chk($sformatf("t2_x%0d", i), x_log[i], t2_x[i]);
        end

        // invisible: rel_y = 116 for a 16px sprite
        base_req = req_cnt;
        send_desc(mk_desc(0, 0, 0, 'h300, 1, 0, 0, 0, 0), 100);
        @(negedge clk_ram);
        chk("inv_ready_calc", desc_ready, 0);
        @(negedge clk_ram);
        chk("inv_ready_back", desc_ready, 1);
        repeat (6) @(negedge clk_ram);
        chk("inv_no_req", req_cnt - base_req, 0);

        // back-pressure with a two-entry FIFO
        @(posedge clk_ram); #1;
        out_ready = 1'b0;
        base_req = req_cnt;
        send_desc(mk_desc(496, 0, 2, 'h80, 'h22, 1, 0, 0, 'h40), 0);
        repeat (20) @(negedge clk_ram);
        chk("full_req_count", req_cnt - base_req, 2);
        chk("full_out_valid", out_valid, 1);
        chk("full_busy", busy, 1);
        @(posedge clk_ram); #1;
        out_ready = 1'b1;
        @(negedge clk_ram);
        chk("pop_cycle_no_req", sdr_req, 0);
        @(posedge clk_ram); #1;
        out_ready = 1'b0;
        @(negedge clk_ram);
        chk("req_after_pop", sdr_req, 1);
        @(posedge clk_ram); #1;
        out_ready = 1'b1;
        wait_idle("full_idle");
        chk("full_total_reqs", req_cnt - base_req, 4);

        // line_start while waiting for data: the late response is dropped
        rdy_delay = 4;
        base_req = req_cnt;
        base_out = out_cnt;
        send_desc(mk_desc(496, 0, 1, 'h40, 3, 0, 0, 0, 'h10), 0);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
                @(negedge clk_ram);
                if (sdr_req) seen = 1'b1;
            end
            chk("ls_req_seen", seen, 1);
        end
        @(posedge clk_ram); #1;
        line_start = 1'b1;
        exp_addr.delete();
        exp_out.delete();
        @(posedge clk_ram); #1;
        line_start = 1'b0;
        @(negedge clk_ram);
        chk("ls_drain_busy", busy, 1);
        chk("ls_drain_no_ready", desc_ready, 0);
        repeat (8) @(negedge clk_ram);
        chk("ls_fifo_empty", out_valid, 0);
        chk("ls_idle", busy, 0);
        chk("ls_req_count", req_cnt - base_req, 1);
        chk("ls_out_count", out_cnt - base_out, 0);
        rdy_delay = 1;

        // a descriptor offered together with line_start is refused
        @(posedge clk_ram); #1;
        line_start = 1'b1;
        desc_in = mk_desc(496, 0, 0, 'h77, 0, 0, 0, 0, 0);
        v_line = '0;
        desc_valid = 1'b1;
        @(negedge clk_ram);
        chk("ls_refuse_desc", desc_ready, 0);
        @(posedge clk_ram); #1;
        line_start = 1'b0;
        desc_valid = 1'b0;
        @(negedge clk_ram);
        chk("ls_refuse_idle", busy, 0);

        // flipy on a 32px sprite: rel_y 3 maps to row 28
        req_log.delete();
        base_out = out_cnt;
        send_desc(mk_desc(0, 1, 0, 'h200, 'h7F, 1, 0, 1, 'h200), 483);
        wait_idle("t6_idle");
        chk("t6_req_count", req_log.size(), 1);
        if (req_log.size() > 0) chk("t6_addr", req_log[0], 25'h500E0);
        chk("t6_out_count", out_cnt - base_out, 1);

        chk("exp_addr_drained", exp_addr.size(), 0);
        chk("exp_out_drained", exp_out.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
